// File: rtl/sat_shift.sv
// Arithmetic right shift followed by saturation to a narrower signed width.
// Purely combinational; shared by the decimating dsp stages.
module sat_shift #(
  parameter int iw = 19,
  parameter int ow = 16
) (
  input  logic signed [iw-1:0] din,
  input  logic        [2:0]    shift,
  output logic signed [ow-1:0] dout
);

  // Output range limits, sign-extended to the input width (requires iw > ow).
  localparam logic signed [iw-1:0] max_v = {{(iw-ow+1){1'b0}}, {(ow-1){1'b1}}};
  localparam logic signed [iw-1:0] min_v = {{(iw-ow+1){1'b1}}, {(ow-1){1'b0}}};

  logic signed [iw-1:0] q;

  always_comb begin
    q = din >>> shift;
    if (q > max_v) begin
      dout = max_v[ow-1:0];
    end else if (q < min_v) begin
      dout = min_v[ow-1:0];
    end else begin
      dout = q[ow-1:0];
    end
  end

endmodule

// File: rtl/phs_avg_comb.sv
// Decimating comb stage of a first-order CIC for the phase-error stream:
// samples the integrator every dec+1 clocks, differences, scales and holds the result.
module phs_avg_comb #(
  parameter int zw = 19,
  parameter int ow = 16,
  parameter int cw = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [zw-1:0] z,
  input  logic                 sync,
  input  logic                 clear,
  input  logic        [cw-1:0] dec,
  input  logic        [2:0]    shift,
  output logic signed [ow-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overrun,
  output logic                 tick
);

  logic        [cw-1:0] cnt_q, cnt_d;
  logic signed [zw-1:0] z_last_q, z_last_d;
  logic signed [zw-1:0] diff_q, diff_d;
  logic                 primed_q, primed_d;
  logic                 s1_valid_q, s1_valid_d;
  logic signed [ow-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 tick_q;
  logic                 tick_i;
  logic signed [ow-1:0] scaled;

  sat_shift #(
    .iw (zw),
    .ow (ow)
  ) u_sat_shift (
    .din   (diff_q),
    .shift (shift),
    .dout  (scaled)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    tick_i       = (cnt_q == '0);
    cnt_d        = sync ? '0 : (tick_i ? dec : cnt_q - cw'(1));
    z_last_d     = z_last_q;
    diff_d       = diff_q;
    primed_d     = primed_q;
    s1_valid_d   = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;

    if (clear) begin
      // dout keeps its stale value; only the bookkeeping is dropped.
      primed_d     = 1'b0;
      z_last_d     = '0;
      dout_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (tick_i) begin
        z_last_d = z;
        if (primed_q) begin
          diff_d     = z - z_last_q;  // wraps mod 2^zw by design
          s1_valid_d = 1'b1;
        end else begin
          primed_d = 1'b1;
        end
      end

      if (s1_valid_q) begin
        dout_d       = scaled;
        dout_valid_d = 1'b1;
        if (dout_valid_q && !dout_ready) overrun_d = 1'b1;
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      z_last_q     <= '0;
      diff_q       <= '0;
      primed_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      z_last_q     <= z_last_d;
      diff_q       <= diff_d;
      primed_q     <= primed_d;
      s1_valid_q   <= s1_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      tick_q       <= tick_i;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_phs_avg_comb.sv
// Self-checking bench for phs_avg_comb: directed scenarios plus random traffic,
// all compared against an integer-arithmetic reference model.
module tb_phs_avg_comb;

  localparam int ZMOD = 1 << 19;

  logic               clk = 1'b0;
  logic               reset_n;
  logic        [18:0] z;
  logic               sync, clear, dout_ready;
  logic        [11:0] dec;
  logic        [2:0]  shift;
  logic signed [15:0] dout;
  logic               dout_valid, overrun, tick;

  phs_avg_comb #(.zw(19), .ow(16), .cw(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .z          (z),
    .sync       (sync),
    .clear      (clear),
    .dec        (dec),
    .shift      (shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int z_u      = 0;
  int z_inc    = 0;

  // Reference model state
  int m_cnt, m_zlast, m_diff, m_dout;
  bit m_primed, m_s1v, m_dv, m_ovr, m_tick;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Difference of two raw integrator samples interpreted as a signed zw-bit value.
  function automatic int wrap_diff(input int a, input int b);
    int d;
    d = (a - b) % ZMOD;
    if (d < 0) d += ZMOD;
    if (d >= ZMOD / 2) d -= ZMOD;
    return d;
  endfunction

  // floor(d / 2^s), clamped to the 16-bit signed range.
  function automatic int scale(input int d, input int s);
    int p, q;
    p = 1 << s;
    if (d >= 0) q = d / p;
    else        q = -((-d + p - 1) / p);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_zlast = 0; m_diff = 0; m_dout = 0;
    m_primed = 0; m_s1v = 0; m_dv = 0; m_ovr = 0; m_tick = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    bit t;
    int ncnt;
    t    = (m_cnt == 0);
    ncnt = sync ? 0 : (t ? int'(dec) : m_cnt - 1);
    if (clear) begin
      m_primed = 0; m_s1v = 0; m_dv = 0; m_ovr = 0; m_zlast = 0;
    end else begin
      if (m_s1v) begin
        if (m_dv && !dout_ready) m_ovr = 1;
        m_dout = scale(m_diff, int'(shift));
        m_dv   = 1;
      end else if (m_dv && dout_ready) begin
        m_dv = 0;
      end
      if (t) begin
        if (m_primed) begin
          m_diff = wrap_diff(z_u, m_zlast);
          m_s1v  = 1;
        end else begin
          m_primed = 1;
          m_s1v    = 0;
        end
        m_zlast = z_u;
      end else begin
        m_s1v = 0;
      end
    end
    m_cnt  = ncnt;
    m_tick = t;
  endtask

  task automatic drive_z();
    z_u = ((z_u + z_inc) % ZMOD + ZMOD) % ZMOD;
    z   = z_u[18:0];
  endtask

  // One clock: model update, edge, compare all outputs, advance z.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("tick", int'(tick), int'(m_tick));
    check("dout_valid", int'(dout_valid), int'(m_dv));
    check("overrun", int'(overrun), int'(m_ovr));
    check("dout", int'(dout), m_dout);
    drive_z();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 300);
  endtask

  int n, nv;
  bit found;

  initial begin
    reset_n = 1'b0; sync = 1'b0; clear = 1'b0; dout_ready = 1'b1;
    dec = 12'd9; shift = 3'd0; z_inc = 5; z_u = 0; z = '0;
    model_reset();
    #12;
    check("rst_tick", int'(tick), 0);
    check("rst_dv", int'(dout_valid), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_dout", int'(dout), 0);
    reset_n = 1'b1;

    // Ramp +5/clock, dec=9: five one-cycle results of 50 in 60 clocks.
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (dout_valid) begin
        nv++;
        check("ramp_val", int'(dout), 50);
      end
    end
    check("ramp_count", nv, 5);

    // Wrap across the positive limit of z, dec=7, +1/clock.
    clear = 1'b1; dec = 12'd7; z_inc = 1; z_u = 262100; z = z_u[18:0];
    cyc();
    clear = 1'b0;
    nv = 0;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (dout_valid) begin
        nv++;
        check("wrap_val", int'(dout), 8);
      end
    end
    check("wrap_seen", int'(nv >= 12), 1);

    // Saturation and shift rounding, tick every clock.
    clear = 1'b1; dec = 12'd0; shift = 3'd0; z_inc = 100000;
    cyc();
    clear = 1'b0;
    run(14);
    check("sat_pos", int'(dout), 32767);
    z_inc = -100000; run(3);
    check("sat_neg", int'(dout), -32768);
    shift = 3'd2; z_inc = 1000; run(3);
    check("shift2", int'(dout), 250);
    shift = 3'd1; z_inc = -7; run(3);
    check("shift1_neg", int'(dout), -4);

    // Handshake: overwrite while stalled, simultaneous consume+load, clear.
    clear = 1'b1; dec = 12'd3; shift = 3'd0; z_inc = 3;
    cyc();
    clear = 1'b0; dout_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      z_inc = i + 1;
      cyc();
    end
    check("hs_ovr_set", int'(overrun), 1);
    check("hs_dv_held", int'(dout_valid), 1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_s1v) found = 1;
      else cyc();
    end
    check("hs_wait", int'(found), 1);
    dout_ready = 1'b1;
    cyc();
    check("hs_same_edge_dv", int'(dout_valid), 1);
    check("hs_same_edge_ovr", int'(overrun), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_ovr", int'(overrun), 0);
    check("clr_dv", int'(dout_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("clr_prime_only", int'(dout_valid), 0);
    end

    // sync and dec change timing.
    dec = 12'd99;
    run(250);
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    cyc();
    check("sync_tick", int'(tick), 1);
    count_to_tick(n);
    check("period_100", n, 100);
    run(30);
    dec = 12'd49;
    count_to_tick(n);
    check("period_finish", n, 70);
    count_to_tick(n);
    check("period_50", n, 50);

    // Asynchronous reset between edges while a result is pending.
    dec = 12'd3; dout_ready = 1'b0; z_inc = 2;
    run(12);
    check("pre_rst_dv", int'(dout_valid), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_dout", int'(dout), 0);
    check("arst_dv", int'(dout_valid), 0);
    check("arst_ovr", int'(overrun), 0);
    check("arst_tick", int'(tick), 0);
    model_reset();
    #2;
    reset_n = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("post_rst_prime", int'(dout_valid), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) dec = 12'($urandom_range(0, 7));
      shift = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) z_inc = int'($urandom_range(0, ZMOD - 1));
      else                           z_inc = int'($urandom_range(0, 4000)) - 2000;
      dout_ready = ($urandom_range(0, 2) != 0);
      sync       = ($urandom_range(0, 49) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      cyc();
    end
    sync = 1'b0; clear = 1'b0;
    run(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
